// File: rtl/led_step_sequencer.sv
// LED step sequencer: edge-detects a divided-clock level into step ticks and walks an LED pattern.
// Optional macro LED_SEQ_INPUT_SYNC_EN adds a 2-flop synchroniser on div_clk_in.
module led_step_sequencer #(
    parameter int NUM_LEDS   = 8,
    parameter int BOTH_EDGES = 0,
    parameter int STEP_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                div_clk_in,
    input  logic                start_i,
    input  logic                pause_i,
    input  logic                stop_i,
    input  logic [1:0]          mode_i,
    output logic                tick_o,
    output logic [NUM_LEDS-1:0] leds_o,
    output logic                busy_o,
    output logic [STEP_W-1:0]   step_cnt_o,
    output logic [1:0]          o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_prev;
    logic                  r_tick;
    logic [NUM_LEDS-1:0]   r_leds;
    logic                  r_busy;
    logic [STEP_W-1:0]     r_step_cnt;
    logic                  r_dir_right;

    logic                  w_din;
    logic                  w_edge;
    logic [NUM_LEDS-1:0]   w_step_leds;
    logic                  w_step_dir;
    logic [NUM_LEDS-1:0]   w_bounce;

`ifdef LED_SEQ_INPUT_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= div_clk_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_din = r_sync2;
`else
    assign w_din = div_clk_in;
`endif

    assign w_edge = (BOTH_EDGES != 0) ? (w_din ^ r_prev) : (w_din & ~r_prev);

    // Next pattern for one step; bounce never wraps, and an emptied pattern restarts at bit0.
    always_comb begin
        w_step_leds = r_leds;
        w_step_dir  = r_dir_right;
        w_bounce    = r_dir_right ? (r_leds >> 1) : (r_leds << 1);
        if (w_bounce == '0) begin
            w_bounce = NUM_LEDS'(1);
        end
        case (mode_i)
            2'b00: w_step_leds = {r_leds[NUM_LEDS-2:0], r_leds[NUM_LEDS-1]};
            2'b01: w_step_leds = {r_leds[0], r_leds[NUM_LEDS-1:1]};
            2'b10: begin
                w_step_leds = w_bounce;
                if (w_bounce[NUM_LEDS-1]) begin
                    w_step_dir = 1'b1;
                end else if (w_bounce[0]) begin
                    w_step_dir = 1'b0;
                end
            end
            default: w_step_leds = (r_leds == '0) ? '1 : '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_prev      <= 1'b0;
            r_tick      <= 1'b0;
            r_leds      <= '0;
            r_busy      <= 1'b0;
            r_step_cnt  <= '0;
            r_dir_right <= 1'b0;
        end else begin
            r_prev <= w_din;
            r_tick <= w_edge;
            if (stop_i) begin
                r_state <= IDLE;
                r_leds  <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_leds <= '0;
                        if (start_i) begin
                            r_state     <= RUN;
                            r_leds      <= NUM_LEDS'(1);
                            r_step_cnt  <= '0;
                            r_dir_right <= 1'b0;
                            r_busy      <= 1'b1;
                        end
                    end
                    RUN: begin
                        // start_i outranks pause_i, so both together keep running.
                        if (pause_i && !start_i) begin
                            r_state <= PAUSE;
                        end
                        if (r_tick) begin
                            r_leds      <= w_step_leds;
                            r_dir_right <= w_step_dir;
                            r_step_cnt  <= r_step_cnt + STEP_W'(1);
                        end
                    end
                    PAUSE: begin
                        if (start_i) begin
                            r_state <= RUN;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_leds  <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tick_o      = r_tick;
    assign leds_o      = r_leds;
    assign busy_o      = r_busy;
    assign step_cnt_o  = r_step_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_led_step_sequencer.sv
// Directed bench for led_step_sequencer: a rising-edge N=4 instance and a both-edge STEP_W=2 instance.
module tb_led_step_sequencer;

`ifdef LED_SEQ_INPUT_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic div1 = 1'b0;
  logic div2 = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic stop = 1'b0;
  logic [1:0] mode = 2'b00;

  logic tick1, busy1, tick2, busy2;
  logic [3:0] leds1, leds2;
  logic [7:0] cnt1;
  logic [1:0] cnt2;
  logic [1:0] st1, st2;

  int n_tests = 0;
  int n_fail = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  led_step_sequencer #(.NUM_LEDS(4), .BOTH_EDGES(0), .STEP_W(8)) dut (
    .clk(clk), .rst(rst), .div_clk_in(div1), .start_i(start), .pause_i(pause),
    .stop_i(stop), .mode_i(mode), .tick_o(tick1), .leds_o(leds1), .busy_o(busy1),
    .step_cnt_o(cnt1), .o_dbg_state(st1)
  );

  led_step_sequencer #(.NUM_LEDS(4), .BOTH_EDGES(1), .STEP_W(2)) dut2 (
    .clk(clk), .rst(rst), .div_clk_in(div2), .start_i(start), .pause_i(pause),
    .stop_i(stop), .mode_i(mode), .tick_o(tick2), .leds_o(leds2), .busy_o(busy2),
    .step_cnt_o(cnt2), .o_dbg_state(st2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl(input logic s, input logic p, input logic t);
    start = s;
    pause = p;
    stop = t;
    cycle();
    start = 1'b0;
    pause = 1'b0;
    stop = 1'b0;
  endtask

  // Drive one div level change and check tick timing, then the pattern one cycle after the tick slot.
  task automatic div_edge(input string tag, input bit sel, input logic lvl, input logic qual,
                          input logic [3:0] el, input logic [7:0] ec);
    logic [11:0] exp;
    logic [11:0] got;
    exp_q.push_back({ec, el});
    if (sel) div2 = lvl;
    else div1 = lvl;
    for (int i = 1; i <= LAT; i++) begin
      cycle();
      check({tag, "_tick"}, sel ? tick2 : tick1, (i == LAT) ? qual : 1'b0);
    end
    cycle();
    check({tag, "_tick_clr"}, sel ? tick2 : tick1, 1'b0);
    exp = exp_q.pop_front();
    got = sel ? {6'd0, cnt2, leds2} : {cnt1, leds1};
    check({tag, "_cnt_leds"}, got, exp);
  endtask

  task automatic tick1_once(input string tag, input logic [3:0] el, input logic [7:0] ec);
    div_edge(tag, 1'b0, 1'b1, 1'b1, el, ec);
    div_edge({tag, "_fall"}, 1'b0, 1'b0, 1'b0, el, ec);
  endtask

  logic [3:0] rl_seq[5] = '{4'd2, 4'd4, 4'd8, 4'd1, 4'd2};
  logic [3:0] bn_seq[7] = '{4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd2};
  logic [3:0] be_seq[5] = '{4'd2, 4'd4, 4'd8, 4'd1, 4'd2};
  logic [1:0] bc_seq[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    // T1: reset values and first rising edge
    repeat (3) cycle();
    check("rst_tick", tick1, 1'b0);
    check("rst_leds", leds1, 4'd0);
    check("rst_busy", busy1, 1'b0);
    check("rst_cnt", cnt1, 8'd0);
    check("rst_state", st1, 2'd0);
    check("rst_leds2", leds2, 4'd0);
    rst = 1'b0;
    cycle();
    cycle();
    check("idle_tick", tick1, 1'b0);
    div_edge("t1_rise", 1'b0, 1'b1, 1'b1, 4'd0, 8'd0);
    div_edge("t1_fall", 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);

    // T2: rotate-left
    mode = 2'b00;
    ctrl(1'b1, 1'b0, 1'b0);
    check("t2_load_leds", leds1, 4'd1);
    check("t2_load_cnt", cnt1, 8'd0);
    check("t2_busy", busy1, 1'b1);
    check("t2_state", st1, 2'd1);
    for (int i = 0; i < 5; i++) tick1_once("t2_rot", rl_seq[i], 8'(i + 1));

    // T3: stop holds count, then bounce
    ctrl(1'b0, 1'b0, 1'b1);
    check("t3_stop_leds", leds1, 4'd0);
    check("t3_stop_busy", busy1, 1'b0);
    check("t3_stop_cnt", cnt1, 8'd5);
    mode = 2'b10;
    ctrl(1'b1, 1'b0, 1'b0);
    check("t3_load_leds", leds1, 4'd1);
    for (int i = 0; i < 7; i++) tick1_once("t3_bounce", bn_seq[i], 8'(i + 1));

    // T4: pause and resume
    ctrl(1'b0, 1'b0, 1'b1);
    mode = 2'b00;
    ctrl(1'b1, 1'b0, 1'b0);
    tick1_once("t4_pre", 4'd2, 8'd1);
    tick1_once("t4_pre", 4'd4, 8'd2);
    ctrl(1'b0, 1'b1, 1'b0);
    check("t4_pause_state", st1, 2'd2);
    check("t4_pause_busy", busy1, 1'b1);
    for (int i = 0; i < 3; i++) tick1_once("t4_frozen", 4'd4, 8'd2);
    ctrl(1'b1, 1'b0, 1'b0);
    check("t4_resume_leds", leds1, 4'd4);
    tick1_once("t4_resume", 4'd8, 8'd3);

    // T5: priority rules
    ctrl(1'b1, 1'b1, 1'b0);
    check("t5_startpause_state", st1, 2'd1);
    tick1_once("t5_wrap", 4'd1, 8'd4);
    ctrl(1'b1, 1'b0, 1'b1);
    check("t5_stopstart_state", st1, 2'd0);
    check("t5_stopstart_leds", leds1, 4'd0);
    check("t5_stopstart_busy", busy1, 1'b0);
    check("t5_stopstart_cnt", cnt1, 8'd4);
    div1 = 1'b1;
    repeat (LAT) cycle();
    check("t5_coinc_tick", tick1, 1'b1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("t5_coinc_leds", leds1, 4'd1);
    check("t5_coinc_cnt", cnt1, 8'd0);
    cycle();
    check("t5_coinc_hold", leds1, 4'd1);
    div_edge("t5_fall", 1'b0, 1'b0, 1'b0, 4'd1, 8'd0);

    // Mode changes mid-run: blink-all, then rotate keeps all-ones
    mode = 2'b11;
    tick1_once("blink_off", 4'd0, 8'd1);
    tick1_once("blink_on", 4'd15, 8'd2);
    mode = 2'b00;
    tick1_once("rotl_ones", 4'd15, 8'd3);
    mode = 2'b01;
    tick1_once("rotr_ones", 4'd15, 8'd4);
    mode = 2'b10;
    tick1_once("bounce_ones", 4'd14, 8'd5);

    // T6: both-edge instance with 2-bit step counter
    ctrl(1'b0, 1'b0, 1'b1);
    mode = 2'b00;
    ctrl(1'b1, 1'b0, 1'b0);
    check("t6_load_leds2", leds2, 4'd1);
    check("t6_load_cnt2", cnt2, 2'd0);
    for (int i = 0; i < 5; i++)
      div_edge("t6_both", 1'b1, ~div2, 1'b1, be_seq[i], 8'(bc_seq[i]));

    // Reset mid-run with div high: all cleared, then one tick after release
    div1 = 1'b1;
    rst = 1'b1;
    cycle();
    check("midrst_leds", leds1, 4'd0);
    check("midrst_busy", busy1, 1'b0);
    check("midrst_cnt", cnt1, 8'd0);
    check("midrst_state", st1, 2'd0);
    check("midrst_tick", tick1, 1'b0);
    check("midrst_leds2", leds2, 4'd0);
    rst = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      cycle();
      check("release_tick", tick1, (i == LAT) ? 1'b1 : 1'b0);
    end
    cycle();
    check("release_tick_clr", tick1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
